// File: rtl/fetch_ctrl_if.sv
// Fetch-side bundle: instruction-memory read port, decode handshake, redirect/halt
// controls and the fault flag. The master modport is the fetch sequencer's view.
interface fetch_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic [31:0]      imem_pc;
  logic [WIDTH-1:0] imem_inst;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_inst;
  logic [31:0]      out_pc;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic             halt;
  logic             fault;

  modport master (
    output imem_pc,
    input  imem_inst,
    output out_valid,
    input  out_ready,
    output out_inst,
    output out_pc,
    input  redirect,
    input  redirect_pc,
    input  halt,
    output fault
  );

  modport slave (
    input  imem_pc,
    output imem_inst,
    input  out_valid,
    output out_ready,
    input  out_inst,
    input  out_pc,
    output redirect,
    output redirect_pc,
    output halt,
    input  fault
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, reads the single-cycle instruction memory and
// buffers {inst, pc} pairs in a 2-entry prefetch FIFO toward decode.
module fetch_ctrl #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned MEM_DEPTH = 16,
  parameter logic [31:0] RESET_PC  = 32'd0
) (
  input  logic         clk,
  input  logic         rst,
  fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {StFetch, StHold, StFault} state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [1:0]       count_q, count_d;
  logic             head_q, head_d;
  logic [WIDTH-1:0] inst_q [2];
  logic [WIDTH-1:0] inst_d [2];
  logic [31:0]      epc_q [2];
  logic [31:0]      epc_d [2];
  logic             fault_q, fault_d;

  logic out_valid;
  logic pop;
  logic in_range;
  logic fetch_ok;
  logic push;
  logic tail;

  assign out_valid = (count_q != 2'd0);
  assign pop       = out_valid & bus.out_ready;
  assign in_range  = (pc_q < 32'(MEM_DEPTH));
  assign fetch_ok  = (state_q == StFetch) & ~bus.halt & in_range;
  // A full FIFO can still accept when the head leaves in the same cycle.
  assign push      = fetch_ok & (~count_q[1] | pop);
  assign tail      = head_q ^ count_q[0];

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    count_d   = count_q;
    head_d    = head_q;
    inst_d[0] = inst_q[0];
    inst_d[1] = inst_q[1];
    epc_d[0]  = epc_q[0];
    epc_d[1]  = epc_q[1];
    fault_d   = fault_q;

    if (bus.redirect) begin
      // Flush wins over everything: no push, no pop this cycle.
      count_d = 2'd0;
      pc_d    = bus.redirect_pc;
      fault_d = 1'b0;
      state_d = bus.halt ? StHold : StFetch;
    end else begin
      if (push) begin
        inst_d[tail] = bus.imem_inst;
        epc_d[tail]  = pc_q;
        pc_d         = pc_q + 32'd1;
      end
      if (pop) begin
        head_d = ~head_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};

      unique case (state_q)
        StFetch: begin
          if (bus.halt) begin
            state_d = StHold;
          end else if (!in_range) begin
            state_d = StFault;
            fault_d = 1'b1;
          end
        end
        StHold: begin
          if (!bus.halt) begin
            state_d = StFetch;
          end
        end
        StFault: state_d = StFault;
        default: state_d = StFetch;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StFetch;
      pc_q      <= RESET_PC;
      count_q   <= 2'd0;
      head_q    <= 1'b0;
      inst_q[0] <= '0;
      inst_q[1] <= '0;
      epc_q[0]  <= '0;
      epc_q[1]  <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      count_q   <= count_d;
      head_q    <= head_d;
      inst_q[0] <= inst_d[0];
      inst_q[1] <= inst_d[1];
      epc_q[0]  <= epc_d[0];
      epc_q[1]  <= epc_d[1];
      fault_q   <= fault_d;
    end
  end

  assign bus.imem_pc   = pc_q;
  assign bus.out_valid = out_valid;
  assign bus.out_inst  = out_valid ? inst_q[head_q] : '0;
  assign bus.out_pc    = out_valid ? epc_q[head_q] : '0;
  assign bus.fault     = fault_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: a program-order scoreboard checks every accepted instruction,
// directed checks cover reset, latency, backpressure, redirect, fault, halt and async reset.
module tb_fetch_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [31:0] exp_q [$];

  fetch_ctrl_if #(.WIDTH(32)) bus ();

  fetch_ctrl #(
    .WIDTH    (32),
    .MEM_DEPTH(16),
    .RESET_PC (32'd0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    case (pc)
      32'd0:   inst_of = 32'h0100_0005;  // MOV
      32'd1:   inst_of = 32'h0110_0007;  // MOV
      32'd2:   inst_of = 32'h0201_0100;  // ADD
      32'd3:   inst_of = 32'h0700_0000;  // BR
      default: inst_of = 32'h5A00_0000 | pc;
    endcase
  endfunction

  assign bus.imem_inst = (bus.imem_pc < 32'd16) ? inst_of(bus.imem_pc) : 32'hDEAD_BEEF;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_range(input int unsigned lo, input int unsigned hi);
    for (int unsigned p = lo; p <= hi; p++) exp_q.push_back(p);
  endtask

  task automatic do_redirect(input logic [31:0] target);
    exp_q.delete();
    bus.redirect    = 1'b1;
    bus.redirect_pc = target;
    step();
    bus.redirect    = 1'b0;
  endtask

  task automatic wait_fault();
    for (int c = 0; c < 40 && !bus.fault; c++) step();
    check_eq("fault_set", 64'(bus.fault), 64'd1);
    check_eq("fault_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("fault_drained", 64'(exp_q.size()), 64'd0);
  endtask

  // Scoreboard: every accepted head must be the next expected PC in program order.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready && !bus.redirect) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected_pc", 64'(bus.out_pc), 64'hFFFF_FFFF);
      end else begin
        logic [31:0] p;
        p = exp_q.pop_front();
        check_eq("sb_pc", 64'(bus.out_pc), 64'(p));
        check_eq("sb_inst", 64'(bus.out_inst), 64'(inst_of(p)));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.out_ready   = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'd0;
    bus.halt        = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_out_inst", 64'(bus.out_inst), 64'd0);
    check_eq("rst_out_pc", 64'(bus.out_pc), 64'd0);
    check_eq("rst_fault", 64'(bus.fault), 64'd0);
    check_eq("rst_imem_pc", 64'(bus.imem_pc), 64'd0);

    // Stream from reset through to the end of memory.
    push_range(0, 15);
    bus.out_ready = 1'b1;
    rst = 1'b0;
    check_eq("stream_imem_pc0", 64'(bus.imem_pc), 64'd0);
    check_eq("stream_valid0", 64'(bus.out_valid), 64'd0);
    for (int i = 1; i <= 5; i++) begin
      step();
      check_eq("stream_imem_pc", 64'(bus.imem_pc), 64'(i));
      check_eq("stream_valid", 64'(bus.out_valid), 64'd1);
      check_eq("stream_out_pc", 64'(bus.out_pc), 64'(i - 1));
    end
    wait_fault();
    check_eq("fault_imem_pc", 64'(bus.imem_pc), 64'd16);

    // Redirect near the top of memory: two words then fault again.
    do_redirect(32'd14);
    push_range(14, 15);
    check_eq("rd14_fault_clr", 64'(bus.fault), 64'd0);
    check_eq("rd14_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rd14_imem_pc", 64'(bus.imem_pc), 64'd14);
    wait_fault();

    // Backpressure: FIFO saturates at two, PC stalls at 2.
    bus.out_ready = 1'b0;
    do_redirect(32'd0);
    push_range(0, 7);
    check_eq("rd0_fault_clr", 64'(bus.fault), 64'd0);
    check_eq("rd0_imem_pc", 64'(bus.imem_pc), 64'd0);
    repeat (5) step();
    check_eq("bp_imem_pc", 64'(bus.imem_pc), 64'd2);
    check_eq("bp_out_pc", 64'(bus.out_pc), 64'd0);
    check_eq("bp_valid", 64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      check_eq("bp_release_pc", 64'(bus.out_pc), 64'(i));
      step();
    end
    bus.out_ready = 1'b0;
    repeat (2) step();

    // Redirect while full: buffered 6,7 are flushed, stream restarts at 2.
    bus.out_ready = 1'b1;
    do_redirect(32'd2);
    push_range(2, 15);
    check_eq("rdfull_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rdfull_imem_pc", 64'(bus.imem_pc), 64'd2);
    step();
    check_eq("rdfull_first_valid", 64'(bus.out_valid), 64'd1);
    check_eq("rdfull_first_pc", 64'(bus.out_pc), 64'd2);
    repeat (2) step();

    // Halt mid-stream: PC freezes at 5, the one buffered entry drains.
    bus.halt = 1'b1;
    step();
    check_eq("halt_drained", 64'(bus.out_valid), 64'd0);
    check_eq("halt_imem_pc", 64'(bus.imem_pc), 64'd5);
    repeat (3) step();
    check_eq("halt_hold_pc", 64'(bus.imem_pc), 64'd5);
    check_eq("halt_hold_valid", 64'(bus.out_valid), 64'd0);
    bus.halt = 1'b0;
    for (int c = 0; c < 6 && !bus.out_valid; c++) step();
    check_eq("halt_resume_valid", 64'(bus.out_valid), 64'd1);
    check_eq("halt_resume_pc", 64'(bus.out_pc), 64'd5);
    repeat (2) step();

    // Asynchronous reset between edges.
    #3;
    rst = 1'b1;
    #1;
    check_eq("arst_valid", 64'(bus.out_valid), 64'd0);
    check_eq("arst_inst", 64'(bus.out_inst), 64'd0);
    check_eq("arst_pc", 64'(bus.out_pc), 64'd0);
    check_eq("arst_fault", 64'(bus.fault), 64'd0);
    check_eq("arst_imem_pc", 64'(bus.imem_pc), 64'd0);
    exp_q.delete();
    push_range(0, 3);
    step();
    rst = 1'b0;
    step();
    check_eq("arst_restart_pc", 64'(bus.out_pc), 64'd0);
    check_eq("arst_restart_valid", 64'(bus.out_valid), 64'd1);
    repeat (3) step();
    check_eq("arst_stream_pc", 64'(bus.out_pc), 64'd3);
    bus.out_ready = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction fetch sequencer for the single-cycle instruction memory. It owns the program counter and drives the memory's combinational read address every cycle. Each fetched word is buffered with its PC in a 2-entry prefetch FIFO, which feeds decode over a valid/ready handshake. It also handles branch redirects from execute, halt requests, and out-of-range fetch faults.

Parameters:
WIDTH, 32, instruction word width (matches `WIDTH).
MEM_DEPTH, 16, number of valid instruction-memory words; legal PCs are 0..MEM_DEPTH-1.
RESET_PC, 0, PC loaded on reset.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
imem_pc  output  32  read address to instruction memory; equals fetch_pc combinationally.
imem_inst  input  WIDTH  combinational read data for imem_pc.
out_valid  output  1  FIFO head holds a valid instruction.
out_ready  input  1  decode accepts head this cycle.
out_inst  output  WIDTH  head instruction word; 0 when out_valid=0.
out_pc  output  32  head instruction PC; 0 when out_valid=0.
redirect  input  1  one-cycle pulse: flush and restart fetch at redirect_pc.
redirect_pc  input  32  redirect target, sampled only when redirect=1.
halt  input  1  level: suspend fetching while high.
fault  output  1  sticky flag: fetch attempted at PC >= MEM_DEPTH.

Behaviour:
- Reset (async, immediate): fetch_pc=RESET_PC; FIFO count=0; entries zeroed; state=FETCH; out_valid=0; out_inst=0; out_pc=0; fault=0.
- States:
  - FETCH: normal fetching.
  - HOLD: entered when halt=1; returns to FETCH when halt=0.
  - FAULT: entered on an out-of-range fetch; left only by redirect or reset.
- Per-cycle definitions:
  - pop = out_valid & out_ready.
  - fetch_ok = state==FETCH & halt==0 & fetch_pc < MEM_DEPTH.
  - push = fetch_ok & (count<2 | pop).
- On push: write {imem_inst, fetch_pc} to the FIFO tail; fetch_pc <= fetch_pc+1.
- On no push: fetch_pc holds.
- Latency: a word at PC p is visible on out_* in the cycle after fetch_pc==p, at the earliest. First out_valid is the 1st rising edge after rst deasserts.
- Throughput: 1 instr/cycle sustained with out_ready=1.
- FIFO ordering:
  - Strict program order, no loss, no duplication.
  - Simultaneous push and pop at count=2 is legal; count stays 2.
  - Pop with count=0 cannot occur, because out_valid=0.
- Fault:
  - Condition: state==FETCH, halt==0, fetch_pc >= MEM_DEPTH.
  - Effect: no push; fault<=1; state<=FAULT; fetch_pc holds.
  - Entries already in the FIFO still drain normally.
- Halt:
  - No pushes while halt=1; fetch_pc holds.
  - FIFO drains via pop.
  - Halt has no effect in FAULT.
- Redirect (highest priority, overrides push, pop, halt and fault):
  - count<=0; fetch_pc<=redirect_pc; fault<=0.
  - Next state: FETCH, or HOLD if halt=1.
  - No push and no pop that cycle, even if out_valid & out_ready.
  - Next cycle: out_valid=0. Fetch restarts from redirect_pc.
- Wrap-around: fetch_pc is a 32-bit increment with no modulo. Running past MEM_DEPTH-1 always faults, never wraps.
- Redirect to an out-of-range PC: accepted, then faults on the following cycle.
- Reset mid-operation: FIFO contents discarded; all outputs return to reset values without waiting for a clock edge.

Test Plan:
- Stream: reset, out_ready=1, memory holds MOV/MOV/ADD/BR -> out_pc 0,1,2,3 on consecutive cycles from the 1st edge after reset; out_inst equals the memory words; imem_pc 0,1,2,3,4 on consecutive cycles.
- Backpressure: out_ready=0 for 5 cycles after reset -> count saturates at 2, imem_pc holds at 2, out_pc holds 0. Then out_ready=1 -> out_pc 0,1,2,3,... with no gap, loss or duplicate.
- Redirect while full: count=2 (entries for PCs 0,1), redirect=1 with redirect_pc=2 and out_ready=1 -> no pop that cycle; out_valid=0 next cycle; next valid out_pc=2; PCs 0 and 1 never appear.
- Fault: MEM_DEPTH=16, redirect_pc=14, out_ready=1 -> out_pc 14,15; fault=1 on the edge where fetch_pc=16; out_valid then 0. A later redirect to 0 -> fault=0 and the stream resumes at PC 0.
- Halt: halt=1 while streaming -> imem_pc freezes; buffered entries drain (at most 2); out_valid=0 afterwards. Release halt -> stream continues from the frozen PC, no gap or duplicate.
- Async reset: assert rst between edges mid-stream -> out_valid, out_inst, out_pc, fault go to 0 and imem_pc goes to RESET_PC before the next edge. Deassert -> stream restarts at PC 0.
